// File: rtl/mem_bridge.sv
// mem_bridge
//   Connects the core's instruction-fetch port and load/store port to the
//   RAMHelper simulation memory. RAMHelper has one read port and one write port.
//   Both core ports share these, and load/store wins any conflict. Byte
//   addresses become 64-bit word indices. Stores are lane-shifted and masked.
//   Load data is realigned and sign- or zero-extended. Every accepted request
//   gets a response exactly one cycle after its grant.
//
// Ports
//   clk, rst           core clock, asynchronous active-high reset
//   if_*               fetch request/grant, 32-bit instruction response
//   ls_*               load/store request/grant, 64-bit response, misalign error
//   ram_ren/ridx       RAMHelper read port (data returns next cycle on ram_rdata)
//   ram_wen/widx/...   RAMHelper write port with per-bit write mask
module mem_bridge #(
  parameter logic [63:0] RAM_BASE = 64'h0000_0000_8000_0000,
  parameter int          IDX_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [63:0]      if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [63:0]      ls_addr,
  input  logic [1:0]       ls_size,
  input  logic             ls_unsigned,
  input  logic [63:0]      ls_wdata,
  output logic             ls_gnt,
  output logic             ls_rvalid,
  output logic [63:0]      ls_rdata,
  output logic             ls_err,
  output logic             ram_ren,
  output logic [IDX_W-1:0] ram_ridx,
  input  logic [63:0]      ram_rdata,
  output logic             ram_wen,
  output logic [IDX_W-1:0] ram_widx,
  output logic [63:0]      ram_wdata,
  output logic [63:0]      ram_wmask
);

  typedef enum logic [2:0] {
    RSP_NONE,
    RSP_IF,
    RSP_LD,
    RSP_ST,
    RSP_ERR
  } rspState_t;

  rspState_t  rspState;
  logic [2:0] rspOff;
  logic [1:0] rspSize;
  logic       rspUnsigned;

  logic             lsGnt;
  logic             ifGnt;
  logic             lsMisaligned;
  logic             lsLoad;
  logic             lsStore;
  logic [2:0]       alignMask;
  logic [63:0]      sizeMask;
  logic [5:0]       laneShift;
  logic [63:0]      ifRel;
  logic [63:0]      lsRel;
  logic [IDX_W-1:0] ifIdx;
  logic [IDX_W-1:0] lsIdx;
  logic [63:0]      ldShifted;
  logic [63:0]      ldExt;

  // Access-size decode: low address bits that must be zero, and byte-lane mask.
  always_comb begin
    alignMask = 3'b000;
    sizeMask  = 64'h0000_0000_0000_00FF;
    case (ls_size)
      2'd0: begin alignMask = 3'b000; sizeMask = 64'h0000_0000_0000_00FF; end
      2'd1: begin alignMask = 3'b001; sizeMask = 64'h0000_0000_0000_FFFF; end
      2'd2: begin alignMask = 3'b011; sizeMask = 64'h0000_0000_FFFF_FFFF; end
      2'd3: begin alignMask = 3'b111; sizeMask = 64'hFFFF_FFFF_FFFF_FFFF; end
      default: ;
    endcase
  end

  assign lsMisaligned = |(ls_addr[2:0] & alignMask);

  // Grants are gated by rst so every output is quiet while reset is held.
  assign lsGnt  = ls_req & ~rst;
  assign ifGnt  = if_req & ~ls_req & ~rst;
  assign if_gnt = ifGnt;
  assign ls_gnt = lsGnt;

  // A misaligned access is granted but does not touch memory.
  assign lsLoad  = lsGnt & ~ls_we & ~lsMisaligned;
  assign lsStore = lsGnt & ls_we & ~lsMisaligned;

  // Word index relative to RAM_BASE. This wraps modulo 2^64, so addresses
  // below RAM_BASE alias high indices. No range check is done.
  assign ifRel = if_addr - RAM_BASE;
  assign lsRel = ls_addr - RAM_BASE;
  assign ifIdx = IDX_W'(ifRel >> 3);
  assign lsIdx = IDX_W'(lsRel >> 3);

  assign laneShift = {ls_addr[2:0], 3'b000};

  assign ram_ren   = lsLoad | ifGnt;
  assign ram_ridx  = lsLoad ? lsIdx : (ifGnt ? ifIdx : '0);
  assign ram_wen   = lsStore;
  assign ram_widx  = lsStore ? lsIdx : '0;
  assign ram_wdata = lsStore ? (ls_wdata << laneShift) : 64'd0;
  assign ram_wmask = lsStore ? (sizeMask << laneShift) : 64'd0;

  // Response tag. It is reloaded every cycle, so it falls back to RSP_NONE
  // whenever nothing was granted. The valid and error flags are registered
  // next to the tag. The data paths stay combinational because RAMHelper
  // only presents ram_rdata in the response cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rspState    <= RSP_NONE;
      rspOff      <= 3'd0;
      rspSize     <= 2'd0;
      rspUnsigned <= 1'b0;
      if_rvalid   <= 1'b0;
      ls_rvalid   <= 1'b0;
      ls_err      <= 1'b0;
    end else begin
      rspState  <= RSP_NONE;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_err    <= 1'b0;
      if (lsGnt) begin
        ls_rvalid <= 1'b1;
        if (lsMisaligned) begin
          rspState <= RSP_ERR;
          ls_err   <= 1'b1;
        end else if (ls_we) begin
          rspState <= RSP_ST;
        end else begin
          rspState    <= RSP_LD;
          rspOff      <= ls_addr[2:0];
          rspSize     <= ls_size;
          rspUnsigned <= ls_unsigned;
        end
      end else if (ifGnt) begin
        rspState  <= RSP_IF;
        if_rvalid <= 1'b1;
        // For fetches, only bit 2 matters. It selects the 32-bit half.
        rspOff    <= {if_addr[2], 2'b00};
      end
    end
  end

  assign ldShifted = ram_rdata >> {rspOff, 3'b000};

  always_comb begin
    ldExt = 64'd0;
    case (rspSize)
      2'd0: ldExt = rspUnsigned ? {56'd0, ldShifted[7:0]}
                                : {{56{ldShifted[7]}}, ldShifted[7:0]};
      2'd1: ldExt = rspUnsigned ? {48'd0, ldShifted[15:0]}
                                : {{48{ldShifted[15]}}, ldShifted[15:0]};
      2'd2: ldExt = rspUnsigned ? {32'd0, ldShifted[31:0]}
                                : {{32{ldShifted[31]}}, ldShifted[31:0]};
      2'd3: ldExt = ldShifted;
      default: ;
    endcase
  end

  assign if_rdata = (rspState == RSP_IF)
                  ? (rspOff[2] ? ram_rdata[63:32] : ram_rdata[31:0])
                  : 32'd0;
  assign ls_rdata = (rspState == RSP_LD) ? ldExt : 64'd0;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge
//   Directed bench for mem_bridge. It includes a small RAMHelper model with a
//   registered read port. When stimulus is issued, the expected responses are
//   pushed into per-port queues. A separate monitor pops those entries and
//   checks data and the one-cycle latency whenever an rvalid appears. Outputs
//   during the grant cycle are checked directly on the falling edge.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [63:0] ls_addr;
  logic [1:0]  ls_size;
  logic        ls_unsigned;
  logic [63:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [63:0] ls_rdata;
  logic        ls_err;
  logic        ram_ren;
  logic [63:0] ram_ridx;
  logic [63:0] ram_rdata;
  logic        ram_wen;
  logic [63:0] ram_widx;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;

  always #5 clk = ~clk;

  mem_bridge dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_unsigned(ls_unsigned), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .ram_ren(ram_ren), .ram_ridx(ram_ridx), .ram_rdata(ram_rdata),
    .ram_wen(ram_wen), .ram_widx(ram_widx), .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask)
  );

  // RAMHelper model: 16 words, registered read, masked write at the clock edge.
  logic [63:0] mem [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 64'd0;
      mem[0] <= 64'h0010_0093_0000_0513;
    end else begin
      if (ram_ren) ram_rdata <= mem[ram_ridx[3:0]];
      if (ram_wen) mem[ram_widx[3:0]] <= (mem[ram_widx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nVec = 0;
  int nMis = 0;

  typedef struct { logic [31:0] data; int due; } ifExp_t;
  typedef struct { logic [63:0] data; logic err; int due; } lsExp_t;
  ifExp_t ifQ[$];
  lsExp_t lsQ[$];
  ifExp_t ifE;
  lsExp_t lsE;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; if_addr = 64'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 64'd0; ls_size = 2'd0;
    ls_unsigned = 1'b0; ls_wdata = 64'd0;
  endtask

  task automatic fetch(input logic [63:0] a, input logic [31:0] d);
    if_req  = 1'b1;
    if_addr = a;
    ifQ.push_back('{data: d, due: cyc + 1});
  endtask

  task automatic lsOp(input logic we, input logic [63:0] a, input logic [1:0] sz,
                      input logic uns, input logic [63:0] wd,
                      input logic [63:0] ed, input logic ee);
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_size = sz;
    ls_unsigned = uns; ls_wdata = wd;
    lsQ.push_back('{data: ed, err: ee, due: cyc + 1});
  endtask

  // Monitor: flags missing, unexpected, wrong or late responses.
  always @(negedge clk) begin
    if (!rst) begin
      while (ifQ.size() > 0 && ifQ[0].due < cyc) begin
        ifE = ifQ.pop_front();
        chk("if_rvalid_missing", 64'd0, 64'd1);
      end
      while (lsQ.size() > 0 && lsQ[0].due < cyc) begin
        lsE = lsQ.pop_front();
        chk("ls_rvalid_missing", 64'd0, 64'd1);
      end
      if (if_rvalid) begin
        $display("cycle %0d: if response rdata=%h", cyc, if_rdata);
        if (ifQ.size() == 0) begin
          chk("if_rvalid_unexpected", 64'd1, 64'd0);
        end else begin
          ifE = ifQ.pop_front();
          chk("if_rdata", 64'(if_rdata), 64'(ifE.data));
          chk("if_latency", 64'(cyc), 64'(ifE.due));
        end
      end
      if (ls_rvalid) begin
        $display("cycle %0d: ls response rdata=%h err=%0b", cyc, ls_rdata, ls_err);
        if (lsQ.size() == 0) begin
          chk("ls_rvalid_unexpected", 64'd1, 64'd0);
        end else begin
          lsE = lsQ.pop_front();
          chk("ls_rdata", ls_rdata, lsE.data);
          chk("ls_err", 64'(ls_err), 64'(lsE.err));
          chk("ls_latency", 64'(cyc), 64'(lsE.due));
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    // Reset state: requests are active, but nothing may be granted or driven.
    if_req = 1'b1; if_addr = 64'h8000_0000;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_0000; ls_size = 2'd3;
    tick();
    tick();
    chk("rst_ls_gnt", 64'(ls_gnt), 64'd0);
    chk("rst_if_gnt", 64'(if_gnt), 64'd0);
    chk("rst_ram_wen", 64'(ram_wen), 64'd0);
    chk("rst_ram_ren", 64'(ram_ren), 64'd0);
    chk("rst_ram_wmask", ram_wmask, 64'd0);
    chk("rst_rvalid", 64'({if_rvalid, ls_rvalid, ls_err}), 64'd0);
    idle();
    rst = 1'b0;

    // Reset mid-flight: a granted fetch is dropped when reset arrives.
    if_req = 1'b1; if_addr = 64'h8000_0004;
    @(negedge clk);
    chk("mid_if_gnt", 64'(if_gnt), 64'd1);
    chk("mid_ram_ren", 64'(ram_ren), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ram_ren", 64'(ram_ren), 64'd0);
    chk("mid_rst_if_gnt", 64'(if_gnt), 64'd0);
    chk("mid_rst_ridx", ram_ridx, 64'd0);
    tick();
    idle();
    chk("mid_rst_if_rvalid", 64'(if_rvalid), 64'd0);
    chk("mid_rst_if_rdata", 64'(if_rdata), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_if_rvalid", 64'(if_rvalid), 64'd0);
    tick();

    // Fetch lane select.
    fetch(64'h8000_0000, 32'h0000_0513);
    @(negedge clk);
    chk("fetch_ridx", ram_ridx, 64'd0);
    tick();
    fetch(64'h8000_0004, 32'h0010_0093);
    tick();
    idle();
    tick();

    // Byte store, then signed and unsigned byte loads.
    lsOp(1'b1, 64'h8000_0013, 2'd0, 1'b0, 64'h80, 64'd0, 1'b0);
    @(negedge clk);
    chk("sb_ram_wen", 64'(ram_wen), 64'd1);
    chk("sb_ram_ren", 64'(ram_ren), 64'd0);
    chk("sb_ram_widx", ram_widx, 64'd2);
    chk("sb_ram_wmask", ram_wmask, 64'h0000_0000_FF00_0000);
    chk("sb_ram_wdata", ram_wdata, 64'h0000_0000_8000_0000);
    tick();
    lsOp(1'b0, 64'h8000_0013, 2'd0, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    tick();
    lsOp(1'b0, 64'h8000_0013, 2'd0, 1'b1, 64'd0, 64'h80, 1'b0);
    tick();

    // Word store in the upper half, then word and half loads.
    lsOp(1'b1, 64'h8000_0014, 2'd2, 1'b0, 64'h8765_4321, 64'd0, 1'b0);
    @(negedge clk);
    chk("sw_ram_wmask", ram_wmask, 64'hFFFF_FFFF_0000_0000);
    chk("sw_ram_wdata", ram_wdata, 64'h8765_4321_0000_0000);
    tick();
    lsOp(1'b0, 64'h8000_0014, 2'd2, 1'b0, 64'd0, 64'hFFFF_FFFF_8765_4321, 1'b0);
    tick();
    lsOp(1'b0, 64'h8000_0014, 2'd2, 1'b1, 64'd0, 64'h0000_0000_8765_4321, 1'b0);
    tick();
    lsOp(1'b0, 64'h8000_0016, 2'd1, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_8765, 1'b0);
    tick();
    lsOp(1'b0, 64'h8000_0012, 2'd1, 1'b1, 64'd0, 64'h0000_0000_0000_8000, 1'b0);
    tick();
    idle();
    tick();

    // Contention: load/store wins for two cycles, then the fetch goes through.
    if_req = 1'b1; if_addr = 64'h8000_0000;
    lsOp(1'b0, 64'h8000_0000, 2'd3, 1'b0, 64'd0, 64'h0010_0093_0000_0513, 1'b0);
    @(negedge clk);
    chk("cont1_ls_gnt", 64'(ls_gnt), 64'd1);
    chk("cont1_if_gnt", 64'(if_gnt), 64'd0);
    tick();
    lsOp(1'b0, 64'h8000_0000, 2'd3, 1'b0, 64'd0, 64'h0010_0093_0000_0513, 1'b0);
    @(negedge clk);
    chk("cont2_ls_gnt", 64'(ls_gnt), 64'd1);
    chk("cont2_if_gnt", 64'(if_gnt), 64'd0);
    tick();
    ls_req = 1'b0;
    fetch(64'h8000_0000, 32'h0000_0513);
    @(negedge clk);
    chk("cont3_if_gnt", 64'(if_gnt), 64'd1);
    tick();
    idle();
    @(negedge clk);
    chk("cont4_if_rvalid", 64'(if_rvalid), 64'd1);
    tick();

    // Misaligned word load and misaligned half store.
    lsOp(1'b0, 64'h8000_0002, 2'd2, 1'b0, 64'd0, 64'd0, 1'b1);
    @(negedge clk);
    chk("mis_lw_ram_ren", 64'(ram_ren), 64'd0);
    chk("mis_lw_ls_gnt", 64'(ls_gnt), 64'd1);
    tick();
    lsOp(1'b1, 64'h8000_0001, 2'd1, 1'b0, 64'hFFFF, 64'd0, 1'b1);
    @(negedge clk);
    chk("mis_sh_ram_wen", 64'(ram_wen), 64'd0);
    tick();
    idle();
    tick();

    // Back-to-back store then load of the same doubleword.
    lsOp(1'b1, 64'h8000_0008, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
    @(negedge clk);
    chk("sd_ram_widx", ram_widx, 64'd1);
    chk("sd_ram_wmask", ram_wmask, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    lsOp(1'b0, 64'h8000_0008, 2'd3, 1'b0, 64'd0, 64'h1122_3344_5566_7788, 1'b0);
    @(negedge clk);
    chk("b2b_ls_rvalid_1", 64'(ls_rvalid), 64'd1);
    tick();
    idle();
    @(negedge clk);
    chk("b2b_ls_rvalid_2", 64'(ls_rvalid), 64'd1);
    tick();
    tick();
    tick();

    chk("if_queue_drained", 64'(ifQ.size()), 64'd0);
    chk("ls_queue_drained", 64'(lsQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits between zerocore and the RAMHelper DPI memory in the simulation top.
- Arbitrates the core's instruction-fetch port and load/store port onto RAMHelper's single read port and single write port.
- Converts byte addresses to 64-bit word indices, builds byte write masks, and aligns, sign- or zero-extends load data.
- Returns every response with a fixed one-cycle latency.

Parameters:
- RAM_BASE, 64'h0000_0000_8000_0000, physical address of RAM word index 0
- IDX_W, 64, width of RAMHelper index ports

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request
- if_addr  in  64  fetch byte address, 4-byte aligned
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  32  fetched instruction
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store
- ls_addr  in  64  byte address
- ls_size  in  2  0 = B, 1 = H, 2 = W, 3 = D
- ls_unsigned  in  1  zero-extend load
- ls_wdata  in  64  store data, LSB-justified
- ls_gnt  out  1  load/store accepted this cycle
- ls_rvalid  out  1  load/store completion
- ls_rdata  out  64  extended load data (0 for stores)
- ls_err  out  1  misaligned access, qualified by ls_rvalid
- ram_ren  out  1  RAMHelper read enable
- ram_ridx  out  64  read word index
- ram_rdata  in  64  read data, registered inside RAMHelper (1-cycle latency)
- ram_wen  out  1  write enable
- ram_widx  out  64  write word index
- ram_wdata  out  64  lane-shifted write data
- ram_wmask  out  64  bit mask, 8 bits per byte lane

Behaviour:
- Reset (asynchronous, active-high) clears:
  - all outputs;
  - the response tag register (state RSP_NONE);
  - the error flag.
- Any in-flight response is discarded on reset. No rvalid is produced after reset deasserts.
- Arbitration is combinational and one request is accepted per cycle.
  - ls_req has priority.
  - if_gnt = if_req & ~ls_req.
  - ls_gnt = ls_req.
- Word index: idx = (addr - RAM_BASE) >> 3, computed modulo 2^64. No range checking.
- Misalignment: addr[2:0] & ((1<<ls_size)-1) != 0.
  - A misaligned access drives no ram_ren/ram_wen.
  - The next cycle gives ls_rvalid=1, ls_err=1, ls_rdata=0.
- Accepted fetch: ram_ren=1, ram_ridx=idx(if_addr). Tag RSP_IF and off=if_addr[2] are registered.
- Accepted aligned load: ram_ren=1, ram_ridx=idx(ls_addr). Tag RSP_LD, off=ls_addr[2:0], size and unsigned are registered.
- Accepted aligned store: ram_wen=1, ram_widx=idx.
  - ram_wdata = ls_wdata << (8*addr[2:0]).
  - ram_wmask = size mask (ff, ffff, ffff_ffff, all ones) << (8*addr[2:0]).
  - Tag RSP_ST is registered.
- Response state machine: RSP_NONE, RSP_IF, RSP_LD, RSP_ST, RSP_ERR. It is reloaded every cycle from the current acceptance, so it returns to RSP_NONE if nothing was accepted.
  - RSP_IF: if_rvalid=1, if_rdata = off ? ram_rdata[63:32] : ram_rdata[31:0].
  - RSP_LD: ls_rvalid=1, ls_rdata = ram_rdata >> (8*off), truncated to size, then sign- or zero-extended.
  - RSP_ST: ls_rvalid=1, ls_rdata=0.
  - RSP_ERR: ls_rvalid=1, ls_err=1.
- Throughput and latency: throughput is one request per cycle. Response latency is exactly 1 cycle after grant.
- Back-to-back requests are allowed, and a response and a new grant may occur in the same cycle.
- Read-after-write: RAMHelper commits the write at the clock edge that ends the store's grant cycle. A load granted the next cycle to the same word returns the new data.
- ram_ren and ram_wen are never both 1 in one cycle.
- Outputs not listed for the current response are held at 0. Request inputs are sampled only in the grant cycle.

Test Plan:
- Reset mid-flight: if_req, if_addr=0x80000004, then rst asserted before the next edge → no if_rvalid; ram_ren=0 and all outputs are 0 while rst is high.
- Fetch lane select: RAM word 0 = 0x00100093_00000513.
  - if_addr 0x80000000 → next cycle if_rdata=0x00000513.
  - if_addr 0x80000004 → next cycle if_rdata=0x00100093.
- Store/load byte: sb 0x80 to 0x80000013.
  - Store cycle: ram_widx=2, ram_wmask=0x0000_0000_FF00_0000, ram_wdata=0x0000_0000_8000_0000.
  - Next cycle: lb → ls_rdata=0xFFFF_FFFF_FFFF_FF80; lbu → 0x80.
- Contention: if_req and ls_req (load) asserted together for 2 cycles, then only if_req.
  - ls_gnt is 1 and if_gnt is 0 in both contention cycles.
  - if_gnt=1 in cycle 3; if_rvalid follows in cycle 4.
- Misaligned: lw at 0x80000002 → ram_ren=0 in the grant cycle; next cycle ls_rvalid=1, ls_err=1, ls_rdata=0.
- Back-to-back: sd 0x1122334455667788 at 0x80000008, then ld at the same address the next cycle → ls_rdata=0x1122334455667788 one cycle later; ls_rvalid is high for 2 consecutive cycles.
